// File: rtl/sorter_pkg.sv
// Shared constants and state encoding for the sorter output path.
package sorter_pkg;
    localparam int SORT_M = 9;
    localparam int SORT_W = 16;
    localparam int NWORDS = 1 << SORT_M;

    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

    // Index width; a single-word frame still needs one bit to name its word.
    function automatic int idx_w(input int m);
        return (m > 0) ? m : 1;
    endfunction
endpackage

// File: rtl/sort_frame_buffer.sv
// Wide capture register for one sorted frame with an indexed word read port.
module sort_frame_buffer
    import sorter_pkg::*;
#(
    parameter int M  = SORT_M,
    parameter int W  = SORT_W,
    parameter int IW = idx_w(M)
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [(1<<M)*W-1:0]   i_data,
    input  logic [IW-1:0]         i_ridx,
    output logic [W-1:0]          o_rdata
);
    localparam int NW = 1 << M;

    logic [NW-1:0][W-1:0] r_mem;

    // Contents are don't-care until the first capture, so no reset.
    always_ff @(posedge clk) begin
        if (i_we)
            r_mem <= i_data;
    end

    assign o_rdata = r_mem[i_ridx];
endmodule

// File: rtl/sort_result_streamer.sv
// Captures a wide sorter result frame and streams it out one word per beat.
module sort_result_streamer
    import sorter_pkg::*;
#(
    parameter int M       = SORT_M,
    parameter int W       = SORT_W,
    parameter int REVERSE = 0,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  res_valid,
    input  logic [(1<<M)*W-1:0]   res_data,
    output logic                  res_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [W-1:0]          out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  overflow,
    output logic [CNT_W-1:0]      drop_count,
    input  logic                  clr_err
);
    localparam int NW = 1 << M;
    localparam int IW = idx_w(M);
    localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);

    state_t          r_state, w_state_nxt;
    logic [IW-1:0]   r_idx, w_idx_nxt, w_ridx;
    logic [W-1:0]    w_rdata;
    logic            w_cap, w_drop, w_xfer, w_last;
    logic            r_overflow;
    logic [CNT_W-1:0] r_drop_count;

    assign w_last    = (r_state == STREAM) && (r_idx == LAST_IDX);
    assign out_valid = (r_state == STREAM);
    assign busy      = (r_state == STREAM);
    assign out_last  = w_last;
    // Accepting during the final beat lets frames run back to back.
    assign res_ready = (r_state == IDLE) | (w_last & out_ready);
    assign w_cap     = res_valid & res_ready;
    assign w_drop    = res_valid & ~res_ready;
    assign w_xfer    = out_valid & out_ready;
    assign w_ridx    = (REVERSE != 0) ? (LAST_IDX - r_idx) : r_idx;
    assign out_data  = out_valid ? w_rdata : '0;

    sort_frame_buffer #(.M(M), .W(W), .IW(IW)) u_buf (
        .clk     (clk),
        .i_we    (w_cap),
        .i_data  (res_data),
        .i_ridx  (w_ridx),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        if (w_cap) begin
            w_state_nxt = STREAM;
            w_idx_nxt   = '0;
        end else if (w_xfer) begin
            if (w_last)
                w_state_nxt = IDLE;
            else
                w_idx_nxt = r_idx + 1'b1;
        end
    end

    // A drop in the same cycle as a clear counts as the first new drop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (clr_err)
                r_drop_count <= CNT_W'(1);
            else if (r_drop_count != '1)
                r_drop_count <= r_drop_count + 1'b1;
        end else if (clr_err) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end
    end

    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;
endmodule

// File: tb/tb_sort_result_streamer.sv
// Directed checks of capture, streaming order, stalls, back-to-back, drops and reset.
module tb_sort_result_streamer;
    import sorter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        res_valid = 1'b0;
    logic [63:0] res_data = '0;
    logic        out_ready = 1'b1;
    logic        clr_err = 1'b0;

    logic        a_res_ready, a_out_valid, a_out_last, a_busy, a_overflow;
    logic [15:0] a_out_data, a_drop_count;
    logic        b_res_ready, b_out_valid, b_out_last, b_busy, b_overflow;
    logic [15:0] b_out_data, b_drop_count;

    logic                       c_res_valid = 1'b0;
    logic [NWORDS*SORT_W-1:0]   c_res_data = '0;
    logic                       c_out_ready = 1'b1;
    logic                       c_clr_err = 1'b0;
    logic                       c_res_ready, c_out_valid, c_out_last, c_busy, c_overflow;
    logic [SORT_W-1:0]          c_out_data;
    logic [15:0]                c_drop_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] fa[4];
    logic [15:0] fr[4];

    always #5 clk = ~clk;

    sort_result_streamer #(.M(2), .W(16), .REVERSE(0), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .res_valid(res_valid), .res_data(res_data),
        .res_ready(a_res_ready), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .out_last(a_out_last), .busy(a_busy),
        .overflow(a_overflow), .drop_count(a_drop_count), .clr_err(clr_err));

    sort_result_streamer #(.M(2), .W(16), .REVERSE(1), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .res_valid(res_valid), .res_data(res_data),
        .res_ready(b_res_ready), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out_data), .out_last(b_out_last), .busy(b_busy),
        .overflow(b_overflow), .drop_count(b_drop_count), .clr_err(clr_err));

    sort_result_streamer #(.M(SORT_M), .W(SORT_W), .REVERSE(0), .CNT_W(16)) dut_c (
        .clk(clk), .rst(rst), .res_valid(c_res_valid), .res_data(c_res_data),
        .res_ready(c_res_ready), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_data(c_out_data), .out_last(c_out_last), .busy(c_busy),
        .overflow(c_overflow), .drop_count(c_drop_count), .clr_err(c_clr_err));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input logic [15:0] w0, input logic [15:0] w1,
                              input logic [15:0] w2, input logic [15:0] w3);
        res_data  = {w3, w2, w1, w0};
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b exp 0", a_out_valid); end
        n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b exp 0", a_busy); end
        n_cmp++; if (a_out_last !== 1'b0) begin n_bad++; $display("FAIL rst_last got %b exp 0", a_out_last); end
        n_cmp++; if (a_out_data !== 16'h0) begin n_bad++; $display("FAIL rst_data got %h exp 0000", a_out_data); end
        n_cmp++; if (a_overflow !== 1'b0) begin n_bad++; $display("FAIL rst_ovf got %b exp 0", a_overflow); end
        n_cmp++; if (a_drop_count !== 16'h0) begin n_bad++; $display("FAIL rst_cnt got %0d exp 0", a_drop_count); end
        n_cmp++; if (a_res_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got %b exp 1", a_res_ready); end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_forward();
        out_ready = 1'b1;
        res_data  = {fa[3], fa[2], fa[1], fa[0]};
        res_valid = 1'b1;
        #1;
        n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL fwd_pre_valid got %b exp 0", a_out_valid); end
        tick();
        res_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if (a_out_valid !== 1'b1) begin n_bad++; $display("FAIL fwd_valid beat %0d got %b exp 1", k, a_out_valid); end
            n_cmp++; if (a_out_data !== fa[k]) begin n_bad++; $display("FAIL fwd_data beat %0d got %h exp %h", k, a_out_data, fa[k]); end
            n_cmp++; if (a_out_last !== (k == 3)) begin n_bad++; $display("FAIL fwd_last beat %0d got %b", k, a_out_last); end
            tick();
        end
        #1;
        n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL fwd_busy_after got %b exp 0", a_busy); end
        n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL fwd_valid_after got %b exp 0", a_out_valid); end
        tick();
    endtask

    task automatic test_reverse_stall();
        int xfers;
        logic [15:0] prev;
        xfers = 0;
        prev  = '0;
        load_frame(fa[0], fa[1], fa[2], fa[3]);
        for (int c = 0; c < 20 && xfers < 4; c++) begin
            out_ready = (c % 3 == 0);
            #1;
            n_cmp++; if (b_out_valid !== 1'b1) begin n_bad++; $display("FAIL rev_valid cyc %0d got %b exp 1", c, b_out_valid); end
            n_cmp++; if (b_out_data !== fr[xfers]) begin n_bad++; $display("FAIL rev_data cyc %0d got %h exp %h", c, b_out_data, fr[xfers]); end
            if (c % 3 != 1 && c > 0) begin
                n_cmp++; if (b_out_data !== prev) begin n_bad++; $display("FAIL rev_hold cyc %0d got %h exp %h", c, b_out_data, prev); end
            end
            prev = b_out_data;
            if (out_ready) xfers++;
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (xfers !== 4) begin n_bad++; $display("FAIL rev_xfers got %0d exp 4", xfers); end
        n_cmp++; if (b_out_valid !== 1'b0) begin n_bad++; $display("FAIL rev_valid_after got %b exp 0", b_out_valid); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] e;
        out_ready = 1'b1;
        load_frame(16'd1, 16'd2, 16'd3, 16'd4);
        for (int k = 0; k < 8; k++) begin
            if (k == 3) begin
                res_data  = {16'd8, 16'd7, 16'd6, 16'd5};
                res_valid = 1'b1;
            end
            #1;
            e = 16'(k + 1);
            if (k == 3) begin
                n_cmp++; if (a_res_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready got %b exp 1", a_res_ready); end
            end
            n_cmp++; if (a_out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid beat %0d got %b exp 1", k, a_out_valid); end
            n_cmp++; if (a_out_data !== e) begin n_bad++; $display("FAIL b2b_data beat %0d got %0d exp %0d", k, a_out_data, e); end
            n_cmp++; if (a_out_last !== (k == 3 || k == 7)) begin n_bad++; $display("FAIL b2b_last beat %0d got %b", k, a_out_last); end
            tick();
            res_valid = 1'b0;
        end
        #1;
        n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_valid_after got %b exp 0", a_out_valid); end
        n_cmp++; if (a_overflow !== 1'b0) begin n_bad++; $display("FAIL b2b_ovf got %b exp 0", a_overflow); end
        tick();
    endtask

    task automatic test_drop();
        out_ready = 1'b1;
        load_frame(16'd11, 16'd22, 16'd33, 16'd44);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                res_data  = {16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D};
                res_valid = 1'b1;
            end
            #1;
            if (k == 1) begin
                n_cmp++; if (a_res_ready !== 1'b0) begin n_bad++; $display("FAIL drop_ready got %b exp 0", a_res_ready); end
            end
            n_cmp++; if (a_out_data !== 16'(11 * (k + 1))) begin n_bad++; $display("FAIL drop_data beat %0d got %0d exp %0d", k, a_out_data, 11 * (k + 1)); end
            tick();
            res_valid = 1'b0;
        end
        #1;
        n_cmp++; if (a_overflow !== 1'b1) begin n_bad++; $display("FAIL drop_ovf got %b exp 1", a_overflow); end
        n_cmp++; if (a_drop_count !== 16'd1) begin n_bad++; $display("FAIL drop_cnt got %0d exp 1", a_drop_count); end
        n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL drop_valid_after got %b exp 0", a_out_valid); end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        #1;
        n_cmp++; if (a_overflow !== 1'b0) begin n_bad++; $display("FAIL clr_ovf got %b exp 0", a_overflow); end
        n_cmp++; if (a_drop_count !== 16'd0) begin n_bad++; $display("FAIL clr_cnt got %0d exp 0", a_drop_count); end
        tick();
        // two drops; the second coincides with a clear, leaving a count of 1
        load_frame(16'd1, 16'd2, 16'd3, 16'd4);
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        #1;
        n_cmp++; if (a_drop_count !== 16'd1) begin n_bad++; $display("FAIL drop2_cnt got %0d exp 1", a_drop_count); end
        res_valid = 1'b1;
        clr_err   = 1'b1;
        tick();
        res_valid = 1'b0;
        clr_err   = 1'b0;
        #1;
        n_cmp++; if (a_overflow !== 1'b1) begin n_bad++; $display("FAIL clrdrop_ovf got %b exp 1", a_overflow); end
        n_cmp++; if (a_drop_count !== 16'd1) begin n_bad++; $display("FAIL clrdrop_cnt got %0d exp 1", a_drop_count); end
        tick();
        tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        load_frame(16'd9, 16'd8, 16'd7, 16'd6);
        rst = 1'b0;
        #1;
        n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_valid got %b exp 0", a_out_valid); end
        n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL mrst_busy got %b exp 0", a_busy); end
        n_cmp++; if (a_out_data !== 16'h0) begin n_bad++; $display("FAIL mrst_data got %h exp 0000", a_out_data); end
        tick();
        tick();
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_stale cyc %0d got %b exp 0", c, a_out_valid); end
        end
        load_frame(16'd5, 16'd6, 16'd7, 16'd8);
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if (a_out_data !== 16'(k + 5)) begin n_bad++; $display("FAIL mrst_new beat %0d got %0d exp %0d", k, a_out_data, k + 5); end
            tick();
        end
    endtask

    task automatic test_full_frame();
        logic [SORT_W-1:0] prev;
        for (int i = 0; i < NWORDS; i++)
            c_res_data[i*SORT_W +: SORT_W] = SORT_W'(NWORDS - 1 - i);
        c_res_valid = 1'b1;
        #1;
        n_cmp++; if (c_res_ready !== 1'b1) begin n_bad++; $display("FAIL full_ready got %b exp 1", c_res_ready); end
        tick();
        c_res_valid = 1'b0;
        prev = '1;
        for (int k = 0; k < NWORDS; k++) begin
            #1;
            n_cmp++;
            if (c_out_valid !== 1'b1 || c_out_data !== SORT_W'(NWORDS - 1 - k) ||
                c_out_last !== (k == NWORDS - 1) || c_out_data > prev) begin
                n_bad++;
                $display("FAIL full_beat %0d got v=%b d=%0d l=%b exp v=1 d=%0d l=%b", k,
                         c_out_valid, c_out_data, c_out_last, NWORDS - 1 - k, k == NWORDS - 1);
            end
            prev = c_out_data;
            tick();
        end
        #1;
        n_cmp++; if (c_out_valid !== 1'b0) begin n_bad++; $display("FAIL full_valid_after got %b exp 0", c_out_valid); end
    endtask

    initial begin
        fa = '{16'd100, 16'd50, 16'hFFFD, 16'hFFF9};
        fr = '{16'hFFF9, 16'hFFFD, 16'd50, 16'd100};
        test_reset();
        test_forward();
        test_reverse_stall();
        test_back_to_back();
        test_drop();
        test_reset_midstream();
        test_full_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
